// File: rtl/hls_macc_pkg.sv
// hls_macc_pkg
//   Shared types and constants for the macc scheduler and its arbiter.
//   - state_t : scheduler FSM encoding (IDLE=0, START=1, WAIT=2, RESP=3)
//   - OPW_DEF / RESW_DEF : default operand bundle / result widths
//   - clog2() : owner-index width for a given requester count
package hls_macc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int OPW_DEF  = 64;
    localparam int RESW_DEF = 32;

    // Ceiling log2, floored at 1 so a 2-requester index is still one bit wide.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin picker. Scans req starting at ptr, wrapping
//   at NREQ, and returns the first set bit.
//   Ports:
//     req  in  NREQ   request vector
//     ptr  in  IDXW   highest-priority index for this scan
//     gnt  out NREQ   one-hot grant (all zero when no request)
//     idx  out IDXW   index of the granted requester
//     any  out 1      at least one request present
module rr_arbiter
    import hls_macc_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDXW = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDXW'(j);
            end
        end
    end

endmodule

// File: rtl/hls_macc_sched.sv
// hls_macc_sched
//   Shares one ap_ctrl_hs multiply-accumulate core between NREQ requesters.
//   Grants round-robin, latches the winner's operands, runs the core
//   start/ready/done handshake, returns the result to the owner and aborts
//   the transaction if the core takes TIMEOUT cycles without done.
//   Ports:
//     ap_clk, ap_rst            clock, synchronous active-high reset
//     req / req_opnd            level requests and per-requester operand slices
//     req_ack                   one-cycle pulse, operands captured
//     rsp_vld/rsp_data/rsp_err  one-cycle response pulse to the owner
//     busy, timeout_err         status (timeout_err is sticky until reset)
//     core_start/core_opnd      drive the core's ap_start and operand inputs
//     core_ready/done/idle      core's ap_ready/ap_done/ap_idle
//     core_result               core output, sampled with core_done
//   All outputs are registered.
module hls_macc_sched
    import hls_macc_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int OPW     = OPW_DEF,
    parameter int RESW    = RESW_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*OPW-1:0]  req_opnd,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      rsp_vld,
    output logic [RESW-1:0]      rsp_data,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 core_start,
    output logic [OPW-1:0]       core_opnd,
    input  logic                 core_ready,
    input  logic                 core_done,
    input  logic                 core_idle,
    input  logic [RESW-1:0]      core_result
);

    localparam int IDXW = clog2(NREQ);

    state_t          state, state_nxt;
    logic [IDXW-1:0] owner, owner_nxt;
    logic [IDXW-1:0] rr_ptr, ptr_nxt, owner_inc;
    logic [15:0]     wdog, wdog_nxt, wdog_inc;
    logic [NREQ-1:0] ack_nxt, vld_nxt;
    logic [RESW-1:0] data_nxt;
    logic [OPW-1:0]  opnd_nxt;
    logic            err_nxt, terr_nxt, start_nxt;

    logic [NREQ-1:0] gnt_oh;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_any;

    rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
        .req (req),
        .ptr (rr_ptr),
        .gnt (gnt_oh),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign wdog_inc  = wdog + 16'd1;
    assign owner_inc = (owner == IDXW'(NREQ - 1)) ? '0 : owner + 1'b1;

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = rr_ptr;
        wdog_nxt  = wdog;
        ack_nxt   = '0;
        vld_nxt   = '0;
        data_nxt  = rsp_data;
        err_nxt   = rsp_err;
        terr_nxt  = timeout_err;
        opnd_nxt  = core_opnd;
        start_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_any && core_idle) begin
                    state_nxt = START;
                    owner_nxt = gnt_idx;
                    ack_nxt   = gnt_oh;
                    opnd_nxt  = req_opnd[int'(gnt_idx)*OPW +: OPW];
                    start_nxt = 1'b1;
                    wdog_nxt  = '0;
                end
            end
            START, WAIT: begin
                wdog_nxt  = wdog_inc;
                start_nxt = (state == START);
                // done beats the watchdog when both land in the same cycle;
                // in START done only counts together with ready.
                if (core_done && (state == WAIT || core_ready)) begin
                    state_nxt = RESP;
                    data_nxt  = core_result;
                    start_nxt = 1'b0;
                end else if (wdog_inc == 16'(TIMEOUT)) begin
                    state_nxt        = IDLE;
                    vld_nxt[owner]   = 1'b1;
                    err_nxt          = 1'b1;
                    data_nxt         = '0;
                    terr_nxt         = 1'b1;
                    ptr_nxt          = owner_inc;
                    start_nxt        = 1'b0;
                end else if (state == START && core_ready) begin
                    state_nxt = WAIT;
                    start_nxt = 1'b0;
                end
            end
            RESP: begin
                state_nxt      = IDLE;
                vld_nxt[owner] = 1'b1;
                err_nxt        = 1'b0;
                ptr_nxt        = owner_inc;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            wdog        <= '0;
            req_ack     <= '0;
            rsp_vld     <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            core_start  <= 1'b0;
            core_opnd   <= '0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            rr_ptr      <= ptr_nxt;
            wdog        <= wdog_nxt;
            req_ack     <= ack_nxt;
            rsp_vld     <= vld_nxt;
            rsp_data    <= data_nxt;
            rsp_err     <= err_nxt;
            busy        <= (state_nxt != IDLE);
            timeout_err <= terr_nxt;
            core_start  <= start_nxt;
            core_opnd   <= opnd_nxt;
        end
    end

endmodule

// File: doc/hls_macc_sched.md
# hls_macc_sched

Round-robin scheduler that shares one HLS-generated multiply-accumulate core (ap_ctrl_hs handshake) between NREQ requesters. It latches the winning requester's operand bundle and drives the core's start/ready/done handshake. It returns the core result to the owner and guards each transaction with a watchdog. It sits between requester logic and the single locked macc instance, and it is the only driver of that core's control inputs.

## Interface
- NREQ, 4: number of requesters, 2..8
- OPW, 64: flattened operand bundle width per requester
- RESW, 32: core result width
- TIMEOUT, 255: maximum cycles from core start to core done before abort, 8..65535
- ap_clk  in  1  clock; all logic on the rising edge
- ap_rst  in  1  reset, synchronous, active-high
- req  in  NREQ  level request per requester; held until its req_ack
- req_opnd  in  NREQ*OPW  operand bundles; slice i belongs to requester i
- req_ack  out  NREQ  one-cycle pulse; operands of that requester were captured
- rsp_vld  out  NREQ  one-cycle pulse to the owner; rsp_data and rsp_err are valid
- rsp_data  out  RESW  result of the last transaction
- rsp_err  out  1  qualifies rsp_vld; 1 = transaction aborted by watchdog
- busy  out  1  high when state is not IDLE
- timeout_err  out  1  sticky; set on any abort, cleared only by ap_rst
- core_start  out  1  to the core's ap_start
- core_opnd  out  OPW  to the core operand inputs; stable from START until IDLE
- core_ready  in  1  from the core's ap_ready
- core_done  in  1  from the core's ap_done
- core_idle  in  1  from the core's ap_idle
- core_result  in  RESW  core output, sampled on core_done

## Operation
- States: IDLE, START, WAIT, RESP.
- IDLE: when any req bit is set and core_idle=1, pick the winner round-robin from rr_ptr upward with wrap. On that edge, latch its slice into core_opnd, store the owner index, pulse req_ack[owner], and go to START.
- If core_idle=0, requests are not granted.
- START: core_start=1.
  - core_ready=1 and core_done=0: go to WAIT.
  - core_ready=1 and core_done=1 in the same cycle: capture core_result and go to RESP.
- WAIT: core_start=0. When core_done=1, capture core_result into rsp_data and go to RESP.
- RESP: pulse rsp_vld[owner] with rsp_err=0, set rr_ptr = owner+1 mod NREQ, and return to IDLE.
- Watchdog:
  - The counter clears on entry to START and increments in START and WAIT.
  - When it equals TIMEOUT with no core_done, set timeout_err. Pulse rsp_vld[owner] with rsp_err=1 and rsp_data=0, deassert core_start, and return to IDLE.
  - rr_ptr still advances after an abort.
- If core_done arrives in the same cycle the counter reaches TIMEOUT, core_done wins and the transaction completes normally.
- A req that drops before its ack is not granted. A req still high after rsp_vld is treated as a new request.
- Reset values: state=IDLE, rr_ptr=0, req_ack=0, rsp_vld=0, rsp_data=0, rsp_err=0, busy=0, timeout_err=0, core_start=0, core_opnd=0, watchdog=0.
- ap_rst asserted mid-transaction:
  - Abandons the transaction on the next edge. No rsp_vld is issued.
  - core_start drops the same edge.
  - The core is expected to be reset by the same ap_rst.

## Timing
- Request seen in IDLE at edge t: req_ack high and core_start high during cycle t+1.
- Core handshake:
  - core_start is held until core_ready is sampled high.
  - It deasserts on the edge after core_ready.
- Result latency: rsp_vld is high one cycle after the edge that sampled core_done.
- For a core with ready and done in its fourth state, the total is 6 cycles from request edge to rsp_vld.
- Back-to-back: the next grant is at the earliest in the cycle after RESP, so there is one idle cycle between transactions.
- All outputs are registered. There are no combinational paths from req to req_ack or from core_done to rsp_vld.

## Structure
- Shared package hls_macc_pkg holds:
  - the state enum (IDLE=0, START=1, WAIT=2, RESP=3)
  - default widths OPW/RESW
  - the owner-index width function clog2(NREQ)
- Sub-module rr_arbiter: NREQ-wide request vector plus rr_ptr in, one-hot grant plus index out, purely combinational. Reused by other shared-resource schedulers.
- The top holds the FSM, operand/result registers, watchdog and rr_ptr.

## Test plan
- Single request: NREQ=4, req=0001, opnd0=0x0000_0003_0000_0005; core model returns 0x0F. Expect:
  - req_ack[0] at t+1
  - one core_start/ready handshake
  - rsp_vld[0] with rsp_data=0x0F and rsp_err=0, 6 cycles after request
- Fairness: req=1111 held continuously for 8 transactions. Grant order must be 0,1,2,3,0,1,2,3, with exactly one rsp_vld per ack.
- Watchdog: TIMEOUT=16 and the core never asserts done. Expect:
  - rsp_vld[owner] with rsp_err=1 and rsp_data=0, 16 cycles after START entry
  - timeout_err stays 1
  - the next request is served normally
- Simultaneous ready and done during START: expect a direct transition to RESP, and rsp_data equal to the core_result sampled that cycle.
- Core busy: core_idle=0 with req=0010. No req_ack while core_idle is low; the grant follows the first cycle core_idle=1.
- Reset mid-WAIT: assert ap_rst for 1 cycle. Expect all outputs at reset values, no rsp_vld, rr_ptr=0, and the next grant going to the lowest active requester.
